// File: rtl/npu_softmax_pkg.sv
// Shared types and constants for the streaming softmax engine: FSM states,
// reciprocal geometry and the elaboration-time exp(-k/2^IN_FRAC) table.
package npu_softmax_pkg;

  localparam int RECIP_NUM_BITS = 32;
  localparam int RECIP_W        = 18;
  localparam int LUT_DEPTH      = 256;
  localparam int LUT_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXP,
    S_RECIP,
    S_NORM,
    S_DONE
  } sm_state_t;

  // Entry k = round(32768 * exp(-k / 2^in_frac)). The base exp(-1/2^in_frac) is
  // built from its Taylor series in Q60, then raised to successive powers.
  function automatic logic [LUT_DEPTH*LUT_W-1:0] build_exp_lut(input int in_frac);
    logic [127:0] one;
    logic [127:0] term;
    logic [127:0] base;
    logic [127:0] v;
    logic [LUT_DEPTH*LUT_W-1:0] lut;
    one  = 128'd1 << 60;
    term = one;
    base = one;
    for (int n = 1; n <= 16; n++) begin
      term = term / (128'(n) << in_frac);
      if ((n % 2) == 1) base = base - term;
      else              base = base + term;
    end
    v   = one;
    lut = '0;
    for (int k = 0; k < LUT_DEPTH; k++) begin
      lut[k*LUT_W +: LUT_W] = LUT_W'((v * 128'd32768 + (128'd1 << 59)) >> 60);
      v = (v * base) >> 60;
    end
    return lut;
  endfunction

endpackage

// File: rtl/recip_divider.sv
// Restoring divider producing floor(2^(NUM_W-1) / divisor), one quotient bit
// per cycle; done pulses once, NUM_W cycles after the cycle start is sampled.
module recip_divider #(
  parameter int DIV_W = 23,
  parameter int NUM_W = 33,
  parameter int Q_W   = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CW = $clog2(NUM_W + 1);

  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] dvs;
  logic [Q_W-1:0]   q;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [DIV_W:0]   rem_sh;
  logic [DIV_W-1:0] diff;
  logic             take;

  // The numerator is a single 1 in its top bit, so only the first step shifts in a 1.
  always_comb begin
    rem_sh = {rem, (cnt == CW'(NUM_W))};
    diff   = rem_sh[DIV_W-1:0] - dvs;
    take   = (rem_sh >= {1'b0, dvs});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dvs  <= '0;
      q    <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= '0;
        dvs <= divisor;
        q   <= '0;
        cnt <= CW'(NUM_W);
        run <= 1'b1;
      end else if (run) begin
        rem <= take ? diff : rem_sh[DIV_W-1:0];
        q   <= {q[Q_W-2:0], take};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = q;

endmodule

// File: rtl/softmax_stream_engine.sv
// Row-streaming fixed-point softmax: buffer logits, exponentiate against the
// row max, take one reciprocal of the sum, then stream normalised probabilities.
module softmax_stream_engine
  import npu_softmax_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 64,
  parameter int IN_FRAC    = 4,
  parameter int EXP_WIDTH  = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LW-1:0]         row_len,
  input  logic [LW-1:0]         row_idx,
  input  logic                  causal_en,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [LW-1:0]         out_col,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int AW     = $clog2(MAX_LEN);
  localparam int SUM_W  = EXP_WIDTH + LW;
  localparam int D_W    = DATA_WIDTH + 1;
  localparam int PROD_W = EXP_WIDTH + RECIP_W;
  localparam int SHIFT  = RECIP_NUM_BITS - OUT_WIDTH;
  localparam logic [LUT_DEPTH*LUT_W-1:0] EXP_LUT = build_exp_lut(IN_FRAC);
  localparam logic [DATA_WIDTH-1:0] MIN_LOGIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  sm_state_t state, state_next;

  logic [LW-1:0]         len;
  logic [LW-1:0]         ridx;
  logic                  cmask;
  logic [LW-1:0]         col;
  logic [DATA_WIDTH-1:0] max_val;
  logic [SUM_W-1:0]      sum;
  logic [RECIP_W-1:0]    recip;
  logic                  div_start;
  logic                  div_done;
  logic [RECIP_W-1:0]    div_q;

  logic [DATA_WIDTH-1:0] logit_buf [MAX_LEN];
  logic [EXP_WIDTH-1:0]  exp_buf   [MAX_LEN];

  logic [AW-1:0]         col_a;
  logic                  last_col;
  logic                  masked;
  logic                  in_fire;
  logic                  out_fire;
  logic [DATA_WIDTH-1:0] x_cur;
  logic [D_W-1:0]        d;
  logic [7:0]            k;
  logic [EXP_WIDTH-1:0]  e_cur;
  logic [PROD_W-1:0]     prod;
  logic [PROD_W-1:0]     scaled;
  logic [OUT_WIDTH-1:0]  sat;

  always_comb begin
    col_a    = col[AW-1:0];
    last_col = (col == len - LW'(1));
    masked   = cmask && (col > ridx);
    in_fire  = (state == S_LOAD) && in_valid;
    out_fire = (state == S_NORM) && out_ready;
    x_cur    = logit_buf[col_a];
    // max >= x for every unmasked column, so the wrapped difference is the true distance.
    d        = {max_val[DATA_WIDTH-1], max_val} - {x_cur[DATA_WIDTH-1], x_cur};
    k        = (d > D_W'(LUT_DEPTH - 1)) ? 8'(LUT_DEPTH - 1) : 8'(d);
    e_cur    = masked ? '0 : EXP_WIDTH'(EXP_LUT[k*LUT_W +: LUT_W]);
    prod     = PROD_W'(exp_buf[col_a]) * PROD_W'(recip);
    scaled   = prod >> SHIFT;
    sat      = (scaled > PROD_W'((1 << OUT_WIDTH) - 1)) ? '1 : scaled[OUT_WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (row_len == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (in_fire && last_col) state_next = S_EXP;
      S_EXP:   if (last_col) state_next = S_RECIP;
      S_RECIP: if (div_done) state_next = S_NORM;
      S_NORM:  if (out_fire && last_col) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      ridx      <= '0;
      cmask     <= 1'b0;
      col       <= '0;
      max_val   <= MIN_LOGIT;
      sum       <= '0;
      recip     <= '0;
      div_start <= 1'b0;
    end else begin
      state     <= state_next;
      div_start <= (state == S_EXP) && last_col;
      case (state)
        S_IDLE: begin
          if (start) begin
            len     <= row_len;
            ridx    <= row_idx;
            cmask   <= causal_en;
            max_val <= MIN_LOGIT;
            sum     <= '0;
            col     <= '0;
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            if (!masked && ($signed(in_data) > $signed(max_val))) max_val <= in_data;
            col <= last_col ? '0 : col + LW'(1);
          end
        end
        S_EXP: begin
          sum <= sum + SUM_W'(e_cur);
          col <= last_col ? '0 : col + LW'(1);
        end
        S_RECIP: begin
          if (div_done) recip <= div_q;
        end
        S_NORM: begin
          if (out_fire) col <= last_col ? '0 : col + LW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) logit_buf[col_a] <= in_data;
    if (state == S_EXP) exp_buf[col_a] <= e_cur;
  end

  recip_divider #(
    .DIV_W (SUM_W),
    .NUM_W (RECIP_NUM_BITS + 1),
    .Q_W   (RECIP_W)
  ) u_recip (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .divisor  (sum),
    .done     (div_done),
    .quotient (div_q)
  );

  // Valid/ready: out_valid holds with out_data/out_col stable until out_ready;
  // a transfer happens on any rising edge where valid and ready are both high.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_NORM);
  assign out_last  = out_valid && last_col;
  assign out_data  = out_valid ? sat : '0;
  assign out_col   = out_valid ? col : '0;

endmodule

// File: tb/tb_softmax_stream_engine.sv
// Self-checking bench for softmax_stream_engine: directed table, corner
// sequences and randomized rows checked against a softmax reference model.
module tb_softmax_stream_engine;

  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] row_len;
  logic [LW-1:0] row_idx;
  logic          causal_en;
  logic          busy;
  logic          done;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic [LW-1:0] out_col;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int xv[64];

  typedef struct {
    int len;
    int ridx;
    int causal;
    int mode;
    int x[8];
    int e[8];
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  softmax_stream_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row_len   (row_len),
    .row_idx   (row_idx),
    .causal_en (causal_en),
    .busy      (busy),
    .done      (done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint exp_entry(input int kk);
    return longint'($rtoi(32768.0 * $exp(-real'(kk) / 16.0) + 0.5));
  endfunction

  // Reference softmax over xv[0..len-1] following the fixed-point rules.
  task automatic model_row(input int len, input int ridx, input int causal);
    int mx;
    int kk;
    longint e[64];
    longint sum;
    longint recip;
    longint o;
    mx  = -128;
    sum = 0;
    for (int c = 0; c < len; c++)
      if (!(causal != 0 && c > ridx) && xv[c] > mx) mx = xv[c];
    for (int c = 0; c < len; c++) begin
      if (causal != 0 && c > ridx) e[c] = 0;
      else begin
        kk = mx - xv[c];
        if (kk > 255) kk = 255;
        e[c] = exp_entry(kk);
      end
      sum += e[c];
    end
    if (len > 0) begin
      recip = (longint'(1) << 32) / sum;
      for (int c = 0; c < len; c++) begin
        o = (e[c] * recip) >> 24;
        if (o > 255) o = 255;
        exp_q.push_back(8'(o));
      end
    end
  endtask

  // Entered at a negedge; runs one row and checks every output beat.
  task automatic run_row(input int len, input int ridx, input int causal, input int mode, input int gaps);
    int idx;
    int outcnt;
    int first_cyc;
    int last_hs;
    int osum;
    bit got_done;
    bit stall;
    bit v;
    bit r;
    logic [7:0] held_d;
    logic [LW-1:0] held_c;
    idx = 0; outcnt = 0; first_cyc = -1; last_hs = -1; osum = 0;
    got_done = 1'b0; stall = 1'b0; held_d = '0; held_c = '0;
    start = 1'b1; row_len = LW'(len); row_idx = LW'(ridx); causal_en = (causal != 0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        chk("done_out_count", outcnt, len);
        chk("done_timing", cyc, (len > 0) ? last_hs + 1 : 0);
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stall) begin
          chk("stall_data", out_data, held_d);
          chk("stall_col", out_col, held_c);
        end
        chk("output_in_range", outcnt < len, 1);
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
        chk("out_col", out_col, outcnt);
        chk("out_last", out_last, outcnt == len - 1);
        if (mode == 0) r = 1'b1;
        else if (mode == 1) r = ((cyc % 3) == 0);
        else r = ($urandom_range(0, 1) == 1);
        out_ready = r;
        if (r) begin
          osum += int'(out_data);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          outcnt++;
          last_hs = cyc;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held_d = out_data;
          held_c = out_col;
        end
      end else begin
        out_ready = ($urandom_range(0, 1) == 1);
        stall = 1'b0;
      end
      if (idx < len) begin
        v = (gaps == 0) || ($urandom_range(0, 3) != 0);
        in_valid = v;
        in_data = 8'(xv[idx]);
        if (v && in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("row_done_seen", got_done, 1);
    if (got_done) begin
      @(negedge clk);
      chk("busy_drop_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
    if (len > 0 && gaps == 0 && causal == 0) chk("first_out_latency", first_cyc, 2 * len + 35);
    if (len > 0) chk("out_sum_le_256", osum <= 256, 1);
    chk("expected_queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_col"}, out_col, 0);
  endtask

  // Reset in the middle of NORM, then a zero-length row.
  task automatic reset_sequence();
    int idx;
    bit seen;
    idx = 0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) xv[c] = int'($urandom_range(0, 60)) - 30;
    start = 1'b1; row_len = LW'(4); row_idx = '0; causal_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        in_valid = (idx < 4);
        in_data = 8'(xv[idx % 4]);
        if (in_valid && in_ready) idx++;
      end
    end
    in_valid = 1'b0;
    chk("reached_norm", seen, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrow_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", done, 0);
      chk("no_valid_after_reset", out_valid, 0);
    end
    start = 1'b1; row_len = '0;
    @(negedge clk);
    chk("len0_done_pulse", done, 1);
    chk("len0_busy", busy, 1);
    chk("len0_no_valid", out_valid, 0);
    row_len = LW'(2);
    @(negedge clk);
    start = 1'b0;
    chk("len0_done_low", done, 0);
    chk("start_in_done_ignored", busy, 0);
    chk("len0_no_valid_after", out_valid, 0);
    @(negedge clk);
    chk("still_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; row_len = '0; row_idx = '0; causal_en = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    vecs[0].len = 4; vecs[0].ridx = 0; vecs[0].causal = 0; vecs[0].mode = 0;
    vecs[0].x = '{0, 0, 0, 0, 0, 0, 0, 0};         vecs[0].e = '{64, 64, 64, 64, 0, 0, 0, 0};
    vecs[1].len = 2; vecs[1].ridx = 0; vecs[1].causal = 0; vecs[1].mode = 0;
    vecs[1].x = '{16, 0, 0, 0, 0, 0, 0, 0};        vecs[1].e = '{187, 68, 0, 0, 0, 0, 0, 0};
    vecs[2].len = 4; vecs[2].ridx = 1; vecs[2].causal = 1; vecs[2].mode = 0;
    vecs[2].x = '{0, 0, 0, 0, 0, 0, 0, 0};         vecs[2].e = '{128, 128, 0, 0, 0, 0, 0, 0};
    vecs[3].len = 4; vecs[3].ridx = 1; vecs[3].causal = 1; vecs[3].mode = 2;
    vecs[3].x = '{0, 0, 100, 100, 0, 0, 0, 0};     vecs[3].e = '{128, 128, 0, 0, 0, 0, 0, 0};
    vecs[4].len = 2; vecs[4].ridx = 0; vecs[4].causal = 0; vecs[4].mode = 0;
    vecs[4].x = '{127, -128, 0, 0, 0, 0, 0, 0};    vecs[4].e = '{255, 0, 0, 0, 0, 0, 0, 0};
    vecs[5].len = 1; vecs[5].ridx = 0; vecs[5].causal = 1; vecs[5].mode = 0;
    vecs[5].x = '{-5, 0, 0, 0, 0, 0, 0, 0};        vecs[5].e = '{255, 0, 0, 0, 0, 0, 0, 0};
    vecs[6].len = 8; vecs[6].ridx = 0; vecs[6].causal = 0; vecs[6].mode = 1;
    vecs[6].x = '{0, 0, 0, 0, 0, 0, 0, 0};         vecs[6].e = '{32, 32, 32, 32, 32, 32, 32, 32};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < 64; c++) xv[c] = (c < 8) ? vecs[i].x[c] : 0;
      for (int c = 0; c < vecs[i].len; c++) exp_q.push_back(8'(vecs[i].e[c]));
      run_row(vecs[i].len, vecs[i].ridx, vecs[i].causal, vecs[i].mode, 0);
    end

    for (int c = 0; c < 8; c++) xv[c] = int'($urandom_range(0, 64)) - 32;
    model_row(8, 0, 0);
    run_row(8, 0, 0, 1, 0);

    reset_sequence();

    for (int n = 0; n < 16; n++) begin
      int len;
      int ridx;
      int causal;
      int gaps;
      len    = int'($urandom_range(1, 64));
      ridx   = int'($urandom_range(0, 64));
      causal = int'($urandom_range(0, 1));
      gaps   = int'($urandom_range(0, 1));
      for (int c = 0; c < 64; c++)
        xv[c] = (n % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 48)) - 24;
      model_row(len, ridx, causal);
      run_row(len, ridx, causal, 2, gaps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
